// File: rtl/rx_filter_scheduler.sv
// Round-robin scheduler sharing one start/active/complete filter among the
// receiver channels; keeps the latest filtered value and a valid flag per channel.
module rx_filter_scheduler #(
   parameter int NUM_CH         = 4,
   parameter int VAL_W          = 8,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                    us_clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       ch_update,
   input  logic [NUM_CH*VAL_W-1:0] ch_value_in,
   output logic                    filt_start,
   output logic [VAL_W-1:0]        filt_value,
   input  logic                    filt_active,
   input  logic                    filt_complete,
   input  logic [VAL_W-1:0]        filt_result,
   output logic [NUM_CH*VAL_W-1:0] ch_value_out,
   output logic [NUM_CH-1:0]       ch_valid,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [2:0]              grant_ch
);

   localparam int                 TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT_ACTIVE,
      S_WAIT_DONE,
      S_STORE,
      S_ABORT
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [7:0]                r_pending;
   logic [2:0]                r_rr_ptr;
   logic [2:0]                r_grant_ch;
   logic [VAL_W-1:0]          r_filt_value;
   logic                      r_filt_start;
   logic                      r_busy;
   logic                      r_timeout_err;
   logic [NUM_CH*VAL_W-1:0]   r_value_out;
   logic [NUM_CH-1:0]         r_valid;
   logic [TMR_W-1:0]          r_timer;

   logic [7:0]                w_upd;
   logic [7:0]                w_clr;
   logic [3:0]                w_idx;
   logic                      w_found;
   logic [2:0]                w_sel;
   logic [2:0]                w_rr_next;
   logic [VAL_W-1:0]          w_sel_val;
   logic                      w_timeout;
   logic                      w_waiting;

   // Pending vector is kept 8 wide so a 3-bit channel index always fits it.
   always_comb begin
      w_upd              = '0;
      w_upd[NUM_CH-1:0]  = ch_update;
      w_clr              = '0;
      if (r_state == S_GRANT) begin
         w_clr[r_grant_ch] = 1'b1;
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_idx = {1'b0, r_rr_ptr} + 4'(i);
         if (w_idx >= 4'(NUM_CH)) begin
            w_idx = w_idx - 4'(NUM_CH);
         end
         if (!w_found && r_pending[w_idx[2:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[2:0];
         end
      end
   end

   always_comb begin
      w_sel_val = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_sel == 3'(k)) begin
            w_sel_val = ch_value_in[k*VAL_W +: VAL_W];
         end
      end
   end

   assign w_rr_next = (w_sel == 3'(NUM_CH - 1)) ? 3'd0 : w_sel + 3'd1;
   assign w_timeout = (r_timer == TMR_MAX);
   assign w_waiting = (r_state == S_WAIT_ACTIVE) || (r_state == S_WAIT_DONE);

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_next = S_GRANT;
         end
         S_GRANT: begin
            w_next = S_WAIT_ACTIVE;
         end
         S_WAIT_ACTIVE: begin
            if (filt_complete)    w_next = S_STORE;
            else if (w_timeout)   w_next = S_ABORT;
            else if (filt_active) w_next = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (filt_complete)    w_next = S_STORE;
            else if (w_timeout)   w_next = S_ABORT;
         end
         S_STORE: begin
            w_next = S_IDLE;
         end
         S_ABORT: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state, so each state's actions are visible while in it.
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_pending     <= '0;
         r_rr_ptr      <= '0;
         r_grant_ch    <= '0;
         r_filt_value  <= '0;
         r_filt_start  <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_value_out   <= '0;
         r_valid       <= '0;
         r_timer       <= '0;
      end else begin
         r_pending    <= (r_pending & ~w_clr) | w_upd;
         r_filt_start <= (w_next == S_GRANT) || (w_next == S_WAIT_ACTIVE);
         r_busy       <= (w_next == S_GRANT) || (w_next == S_WAIT_ACTIVE) ||
                         (w_next == S_WAIT_DONE);
         if (r_state == S_IDLE && w_found) begin
            r_grant_ch   <= w_sel;
            r_filt_value <= w_sel_val;
            r_rr_ptr     <= w_rr_next;
         end
         if (r_state == S_GRANT) begin
            r_timer <= '0;
         end else if (w_waiting && !w_timeout) begin
            r_timer <= r_timer + TMR_W'(1);
         end
         if (w_waiting && w_next == S_STORE) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (r_grant_ch == 3'(k)) begin
                  r_value_out[k*VAL_W +: VAL_W] <= filt_result;
                  r_valid[k]                    <= 1'b1;
               end
            end
         end
         if (w_next == S_ABORT) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign filt_start   = r_filt_start;
   assign filt_value   = r_filt_value;
   assign ch_value_out = r_value_out;
   assign ch_valid     = r_valid;
   assign busy         = r_busy;
   assign timeout_err  = r_timeout_err;
   assign grant_ch     = r_grant_ch;

endmodule

// File: tb/tb_rx_filter_scheduler.sv
// Directed bench for rx_filter_scheduler: a filter model answers passes, and a
// scoreboard of expected grants (channel, operand) is checked at each filt_start rise.
`timescale 1ns/1ps
module tb_rx_filter_scheduler;

   localparam int NUM_CH = 4;
   localparam int VAL_W  = 8;
   localparam int TO     = 32;

   logic                    us_clk = 1'b0;
   logic                    resetn = 1'b0;
   logic [NUM_CH-1:0]       ch_update = '0;
   logic [NUM_CH*VAL_W-1:0] ch_value_in = '0;
   logic                    filt_start;
   logic [VAL_W-1:0]        filt_value;
   logic                    filt_active;
   logic                    filt_complete;
   logic [VAL_W-1:0]        filt_result;
   logic [NUM_CH*VAL_W-1:0] ch_value_out;
   logic [NUM_CH-1:0]       ch_valid;
   logic                    busy;
   logic                    timeout_err;
   logic [2:0]              grant_ch;

   typedef struct packed {
      logic [2:0] ch;
      logic [7:0] val;
   } grant_t;

   grant_t exp_q[$];
   int     n_checks = 0;
   int     n_errors = 0;

   // filter model controls
   int         m_delay  = 6;
   logic [7:0] m_offset = 8'd0;
   bit         m_never  = 1'b0;
   logic       t_stray  = 1'b0;
   logic       m_busy;
   int         m_cnt;
   logic [7:0] m_val;
   logic       m_active;
   logic       m_complete;
   logic [7:0] m_result;

   always #5 us_clk = ~us_clk;

   rx_filter_scheduler #(
      .NUM_CH(NUM_CH), .VAL_W(VAL_W), .TIMEOUT_CYCLES(TO)
   ) dut (
      .us_clk        (us_clk),
      .resetn        (resetn),
      .ch_update     (ch_update),
      .ch_value_in   (ch_value_in),
      .filt_start    (filt_start),
      .filt_value    (filt_value),
      .filt_active   (filt_active),
      .filt_complete (filt_complete),
      .filt_result   (filt_result),
      .ch_value_out  (ch_value_out),
      .ch_valid      (ch_valid),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .grant_ch      (grant_ch)
   );

   assign filt_active   = m_active;
   assign filt_complete = m_complete | t_stray;
   assign filt_result   = t_stray ? 8'd200 : m_result;

   // Filter model: accepts a start, raises active, completes m_delay cycles later
   // with value + m_offset, or never completes when m_never is set.
   always @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         m_busy     <= 1'b0;
         m_cnt      <= 0;
         m_val      <= '0;
         m_active   <= 1'b0;
         m_complete <= 1'b0;
         m_result   <= '0;
      end else begin
         m_complete <= 1'b0;
         if (!m_busy) begin
            if (filt_start) begin
               m_busy   <= 1'b1;
               m_cnt    <= 1;
               m_val    <= filt_value;
               m_active <= 1'b1;
            end
         end else if (!busy) begin
            m_busy   <= 1'b0;
            m_active <= 1'b0;
         end else if (!m_never && m_cnt == m_delay) begin
            m_complete <= 1'b1;
            m_result   <= m_val + m_offset;
            m_busy     <= 1'b0;
            m_active   <= 1'b0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic grant_t mk(input int ch, input int v);
      grant_t g;
      g.ch  = 3'(ch);
      g.val = 8'(v);
      return g;
   endfunction

   task automatic tick();
      @(negedge us_clk);
   endtask

   task automatic set_val(input int ch, input logic [7:0] v);
      ch_value_in[ch*VAL_W +: VAL_W] = v;
   endtask

   task automatic pulse(input logic [NUM_CH-1:0] m);
      ch_update = m;
      tick();
      ch_update = '0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(exp_q.size() == 0 && !busy) && n < budget);
      chk({tag, "_drain"}, (exp_q.size() == 0 && !busy), 1);
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      ch_update = '0;
      t_stray   = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      tick();
   endtask

   // Scoreboard monitor: every new filt_start must match the oldest expected grant.
   initial begin
      logic   prev;
      grant_t g;
      prev = 1'b0;
      forever begin
         @(negedge us_clk);
         if (filt_start && !prev) begin
            chk("sb_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               g = exp_q.pop_front();
               chk("grant_ch", grant_ch, g.ch);
               chk("grant_val", filt_value, g.val);
            end
         end
         prev = filt_start;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) tick();
      chk("rst_start", filt_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", ch_valid, 0);
      chk("rst_out", ch_value_out, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_grant", grant_ch, 0);
      chk("rst_fval", filt_value, 0);
      resetn = 1'b1;
      tick();

      // single request, latency and +50 filter
      m_delay = 6; m_offset = 8'd50;
      set_val(0, 8'd100);
      exp_q.push_back(mk(0, 100));
      ch_update = 4'b0001;
      tick();
      ch_update = '0;
      chk("lat_cycle1", filt_start, 0);
      tick();
      chk("lat_cycle2", filt_start, 1);
      drain("single", 100);
      chk("single_out0", ch_value_out[7:0], 150);
      chk("single_valid", ch_valid, 4'b0001);
      chk("single_busy", busy, 0);

      // round robin from a fresh pointer, identity filter
      do_reset();
      m_delay = 3; m_offset = 8'd0;
      set_val(0, 8'd10); set_val(1, 8'd20); set_val(2, 8'd30); set_val(3, 8'd40);
      exp_q.push_back(mk(0, 10)); exp_q.push_back(mk(1, 20));
      exp_q.push_back(mk(2, 30)); exp_q.push_back(mk(3, 40));
      pulse(4'b1111);
      n = 0;
      while (!(busy && grant_ch == 3'd3) && n < 100) begin tick(); n++; end
      chk("rr_reach_ch3", busy && grant_ch == 3'd3, 1);
      set_val(1, 8'd21); set_val(3, 8'd41);
      exp_q.push_back(mk(1, 21)); exp_q.push_back(mk(3, 41));
      pulse(4'b1010);
      drain("rr", 200);
      chk("rr_out", ch_value_out, {8'd41, 8'd30, 8'd21, 8'd10});
      chk("rr_valid", ch_valid, 4'b1111);

      // update of ch2 coinciding with its GRANT cycle
      m_offset = 8'd3;
      set_val(2, 8'd55);
      exp_q.push_back(mk(2, 55));
      pulse(4'b0100);
      n = 0;
      while (!filt_start && n < 10) begin tick(); n++; end
      chk("ug_grant_seen", filt_start && grant_ch == 3'd2, 1);
      set_val(2, 8'd77);
      exp_q.push_back(mk(2, 77));
      pulse(4'b0100);
      drain("ug", 100);
      chk("ug_out2", ch_value_out[23:16], 80);

      // timeout on ch0, ch1 queued behind it
      m_never = 1'b1;
      set_val(0, 8'd5); set_val(1, 8'd6);
      exp_q.push_back(mk(0, 5));
      pulse(4'b0001);
      n = 0;
      while (!filt_start && n < 10) begin tick(); n++; end
      chk("to_grant", filt_start, 1);
      exp_q.push_back(mk(1, 6));
      pulse(4'b0010);
      n = 1;
      while (!timeout_err && n < 100) begin tick(); n++; end
      chk("to_cycles", n, TO + 2);
      m_never = 1'b0;
      drain("to", 100);
      chk("to_sticky", timeout_err, 1);
      chk("to_valid", ch_valid, 4'b1111);
      chk("to_out", ch_value_out, {8'd41, 8'd80, 8'd9, 8'd10});

      // stray complete while idle
      t_stray = 1'b1;
      tick();
      t_stray = 1'b0;
      tick();
      chk("stray_out", ch_value_out, {8'd41, 8'd80, 8'd9, 8'd10});
      chk("stray_valid", ch_valid, 4'b1111);
      chk("stray_busy", busy, 0);
      chk("stray_terr", timeout_err, 1);

      // reset during WAIT_DONE with ch3 pending
      m_delay = 20; m_offset = 8'd0;
      set_val(2, 8'd123);
      exp_q.push_back(mk(2, 123));
      pulse(4'b0100);
      n = 0;
      while (!(busy && !filt_start) && n < 20) begin tick(); n++; end
      chk("mr_in_wait_done", busy && !filt_start, 1);
      pulse(4'b1000);
      resetn = 1'b0;
      #1;
      chk("mr_start", filt_start, 0);
      chk("mr_busy", busy, 0);
      chk("mr_valid", ch_valid, 0);
      chk("mr_out", ch_value_out, 0);
      chk("mr_terr", timeout_err, 0);
      chk("mr_grant", grant_ch, 0);
      chk("mr_fval", filt_value, 0);
      repeat (2) tick();
      resetn = 1'b1;
      repeat (6) tick();
      chk("mr_pending_lost_start", filt_start, 0);
      chk("mr_pending_lost_busy", busy, 0);
      set_val(1, 8'd66);
      exp_q.push_back(mk(1, 66));
      pulse(4'b0010);
      drain("mr", 100);
      chk("mr_after_out", ch_value_out, {8'd0, 8'd0, 8'd66, 8'd0});
      chk("mr_after_valid", ch_valid, 4'b0010);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
